// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the dmem round-robin arbiter.
// The optional atomic-hold feature is enabled with DMEM_ATOMIC_EN.
package dmem_arb_pkg;

  localparam int NCORE_DEF = 4;
  localparam int AW_DEF    = 16;
  localparam int DW_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Low bit of core `core`'s field inside a flattened per-core bus.
  function automatic int slice_lo(input int core, input int width);
    return core * width;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or above ptr_i,
// wrapping at N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0] cand;

  // NOTE: every output and temporary gets a default first, so no path through this block infers a latch.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!any_o && elig_i[cand[IW-1:0]]) begin
        any_o               = 1'b1;
        idx_o               = cand[IW-1:0];
        gnt_o[cand[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port dmem between NCORE cores.
// Defining DMEM_ATOMIC_EN adds the lock port for atomic read-modify-write holds.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NCORE = NCORE_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NCORE-1:0]    req,
  input  logic [NCORE-1:0]    we,
  input  logic [NCORE*AW-1:0] addr,
  input  logic [NCORE*DW-1:0] wdata,
`ifdef DMEM_ATOMIC_EN
  input  logic [NCORE-1:0]    lock,
`endif
  output logic [NCORE-1:0]    ack,
  output logic [NCORE-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       mem_address,
  output logic [DW-1:0]       mem_data,
  output logic                mem_wren,
  input  logic [DW-1:0]       mem_q
);

  localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [NCORE-1:0] gnt_oh_q, gnt_oh_d;
  logic [NCORE-1:0] ack_q, ack_d;
  logic [NCORE-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [AW-1:0]    mem_address_q, mem_address_d;
  logic [DW-1:0]    mem_data_q, mem_data_d;
  logic             mem_wren_q, mem_wren_d;
`ifdef DMEM_ATOMIC_EN
  logic             locked_q, locked_d;
`endif

  logic [NCORE-1:0] elig;
  logic [NCORE-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;
  logic             sel_we;

  // The core being acked this cycle still holds req, so mask it out.
  always_comb begin
    elig = req & ~ack_q;
`ifdef DMEM_ATOMIC_EN
    if (locked_q && lock[gnt_q]) elig = elig & gnt_oh_q;
`endif
  end

  rr_pick #(
    .N  (NCORE),
    .IW (IW)
  ) u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NCORE; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_addr  = addr[slice_lo(i, AW) +: AW];
        sel_wdata = wdata[slice_lo(i, DW) +: DW];
        sel_we    = we[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    gnt_oh_d      = gnt_oh_q;
    ack_d         = '0;
    rvalid_d      = '0;
    rdata_d       = rdata_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
`ifdef DMEM_ATOMIC_EN
    locked_d      = locked_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef DMEM_ATOMIC_EN
        if (locked_q && !lock[gnt_q]) locked_d = 1'b0;
`endif
        if (pick_any) begin
          gnt_d         = pick_idx;
          gnt_oh_d      = pick_oh;
          mem_address_d = sel_addr;
          mem_data_d    = sel_wdata;
          mem_wren_d    = sel_we;
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        ptr_d = (gnt_q == IW'(NCORE-1)) ? '0 : gnt_q + IW'(1);
`ifdef DMEM_ATOMIC_EN
        // A locked core keeps the pointer and exclusive eligibility.
        locked_d = lock[gnt_q];
        if (lock[gnt_q]) ptr_d = ptr_q;
`endif
        if (mem_wren_q) begin
          ack_d   = gnt_oh_q;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        rdata_d  = mem_q;
        ack_d    = gnt_oh_q;
        rvalid_d = gnt_oh_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      gnt_oh_q      <= '0;
      ack_q         <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
`ifdef DMEM_ATOMIC_EN
      locked_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      gnt_oh_q      <= gnt_oh_d;
      ack_q         <= ack_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
`ifdef DMEM_ATOMIC_EN
      locked_q      <= locked_d;
`endif
    end
  end

  assign ack         = ack_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;

endmodule
